xor_share_arb: RTL and testbench
================================

Name: xor_share_arb

Overview:
- Shares one registered WIDTH-bit XOR datapath between two requesters (ch0, ch1).
- Each requester submits operand pairs over a valid/ready handshake. A round-robin arbiter picks one per cycle.
- The result is held in a single-entry output register with valid/ready backpressure. It is tagged with the originating channel and its parity.
- Per-channel completion counters are provided for debug and throughput checks.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1)
- CNT_W, 8, width of each per-channel completion counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  ch0 has an operand pair
- req0_a  input  WIDTH  ch0 operand a
- req0_b  input  WIDTH  ch0 operand b
- req0_ready  output  1  ch0 pair accepted this cycle
- req1_valid  input  1  ch1 has an operand pair
- req1_a  input  WIDTH  ch1 operand a
- req1_b  input  WIDTH  ch1 operand b
- req1_ready  output  1  ch1 pair accepted this cycle
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes the result
- out_o  output  WIDTH  a ^ b of the granted pair
- out_id  output  1  channel of the result (0/1)
- out_par  output  1  XOR-reduction of out_o (odd parity)
- done_cnt0  output  CNT_W  results from ch0 taken by the consumer
- done_cnt1  output  CNT_W  results from ch1 taken by the consumer

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_o=0, out_id=0, out_par=0, done_cnt0=0, done_cnt1=0.
  - Internal last_grant=1, so ch0 wins the first contention.
  - req*_ready are combinational and are 0 while rst=1.
  - A pending result is discarded. Counters do not count it.
- Slot free: slot_free = !out_valid | out_ready. A pass-through in the same cycle is allowed.
- Arbitration (combinational, only when slot_free=1 and rst=0):
  - Only ch0 valid -> grant ch0.
  - Only ch1 valid -> grant ch1.
  - Both valid -> grant the channel != last_grant.
  - Neither valid -> no grant.
- reqN_ready = grantN. At most one ready is high per cycle. Ready may depend on valid. Requesters must not make valid depend on ready.
- Requester rule: valid and operands stay stable until ready. Checker: valid must not drop without a handshake.
- Transfer: on a clk edge with reqN_valid & reqN_ready:
  - out_o <= reqN_a ^ reqN_b
  - out_id <= N
  - out_par <= ^(reqN_a ^ reqN_b)
  - out_valid <= 1
  - last_grant <= N
- Latency: one cycle from acceptance to out_valid.
- Throughput: one result per cycle when out_ready is held at 1.
- Drain: out_valid & out_ready with no new grant -> out_valid <= 0. out_o, out_id and out_par hold their last values.
- Backpressure: out_valid=1 & out_ready=0 -> both readies are 0 and the output is frozen.
- Counting:
  - done_cntN increments on out_valid & out_ready & (out_id==N).
  - Wraps modulo 2^CNT_W (0xFF -> 0x00 at defaults).
  - A simultaneous drain and new grant counts the drained result only.
- last_grant updates only on an actual grant. Idle cycles keep the priority unchanged.
- No starvation: a continuously valid channel is granted within 2 slot-free cycles.

Test Plan:
- Reset, then ch0 only, a=0x0F b=0xFF, out_ready=1 -> req0_ready=1 in cycle 0. Next cycle out_o=0xF0, out_id=0, out_par=0, out_valid=1; then done_cnt0=1.
- Both channels valid continuously, out_ready=1, ch0 a^b=0x01, ch1 a^b=0x03 -> out_id sequence 0,1,0,1…, out_par 1,0,1,0…, one result per cycle.
- Result present, out_ready=0 for 3 cycles while both request -> req0_ready=req1_ready=0, out_o unchanged. On release, the next grant follows round-robin order.
- 256 ch1 transfers with out_ready=1 -> done_cnt1 wraps to 0x00, done_cnt0 stays 0.
- Assert rst while out_valid=1 and both requests are pending -> next cycle out_valid=0, counters 0, readies 0 during rst. First grant after release goes to ch0.
- Exhaustive 1-bit sweep (WIDTH=1) of a,b over 00,10,01,11 on ch0 -> out_o 0,1,1,0 and out_par equals out_o.

Source files
------------

// File: rtl/xor_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : xor_share_arb
// Brief    : One registered XOR datapath shared by two valid/ready requesters
//            through a round-robin arbiter, with a tagged single-entry output
//            register and per-channel completion counters.
// Revision : 1.0
// ============================================================================
module xor_share_arb #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_o,
    output logic             out_id,
    output logic             out_par,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic             w_slot_free;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_take;
    logic [WIDTH-1:0] w_xor;

    logic             r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0] r_out_o_q,     w_out_o_d;
    logic             r_out_id_q,    w_out_id_d;
    logic             r_out_par_q,   w_out_par_d;
    logic             r_last_grant_q, w_last_grant_d;
    logic [CNT_W-1:0] r_done_cnt0_q, w_done_cnt0_d;
    logic [CNT_W-1:0] r_done_cnt1_q, w_done_cnt1_d;

    // On contention the channel that did not win last time is served.
    assign w_slot_free = !r_out_valid_q || out_ready;
    assign w_grant0    = !rst && w_slot_free && req0_valid && (!req1_valid ||  r_last_grant_q);
    assign w_grant1    = !rst && w_slot_free && req1_valid && (!req0_valid || !r_last_grant_q);
    assign w_take      = r_out_valid_q && out_ready;
    assign w_xor       = w_grant1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);

    always_comb begin
        w_out_valid_d  = r_out_valid_q;
        w_out_o_d      = r_out_o_q;
        w_out_id_d     = r_out_id_q;
        w_out_par_d    = r_out_par_q;
        w_last_grant_d = r_last_grant_q;
        w_done_cnt0_d  = r_done_cnt0_q;
        w_done_cnt1_d  = r_done_cnt1_q;

        // The drained result is counted even when a new grant refills the slot.
        if (w_take) begin
            if (r_out_id_q) begin
                w_done_cnt1_d = r_done_cnt1_q + C_CNT_ONE;
            end else begin
                w_done_cnt0_d = r_done_cnt0_q + C_CNT_ONE;
            end
        end

        if (w_grant0 || w_grant1) begin
            w_out_valid_d  = 1'b1;
            w_out_o_d      = w_xor;
            w_out_id_d     = w_grant1;
            w_out_par_d    = ^w_xor;
            w_last_grant_d = w_grant1;
        end else if (w_take) begin
            w_out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q  <= 1'b0;
            r_out_o_q      <= '0;
            r_out_id_q     <= 1'b0;
            r_out_par_q    <= 1'b0;
            r_last_grant_q <= 1'b1;
            r_done_cnt0_q  <= '0;
            r_done_cnt1_q  <= '0;
        end else begin
            r_out_valid_q  <= w_out_valid_d;
            r_out_o_q      <= w_out_o_d;
            r_out_id_q     <= w_out_id_d;
            r_out_par_q    <= w_out_par_d;
            r_last_grant_q <= w_last_grant_d;
            r_done_cnt0_q  <= w_done_cnt0_d;
            r_done_cnt1_q  <= w_done_cnt1_d;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign out_valid  = r_out_valid_q;
    assign out_o      = r_out_o_q;
    assign out_id     = r_out_id_q;
    assign out_par    = r_out_par_q;
    assign done_cnt0  = r_done_cnt0_q;
    assign done_cnt1  = r_done_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_share_arb
// Brief    : Self-checking bench: directed table, wrap/sweep sequences and
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_xor_share_arb;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       out_valid, out_ready, out_id, out_par;
    logic [7:0] out_o, done_cnt0, done_cnt1;

    // 1-bit instance for the exhaustive operand sweep
    logic       s_v0, s_v1, s_r0, s_r1, s_ov, s_id, s_par;
    logic [0:0] s_a0, s_b0, s_a1, s_b1, s_o;
    logic [7:0] s_c0, s_c1;

    int n_vec = 0;
    int n_err = 0;

    xor_share_arb #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_o(out_o), .out_id(out_id),
        .out_par(out_par), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    xor_share_arb #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_v0), .req0_a(s_a0), .req0_b(s_b0), .req0_ready(s_r0),
        .req1_valid(s_v1), .req1_a(s_a1), .req1_b(s_b1), .req1_ready(s_r1),
        .out_valid(s_ov), .out_ready(1'b1), .out_o(s_o), .out_id(s_id),
        .out_par(s_par), .done_cnt0(s_c0), .done_cnt1(s_c1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input logic v, input logic [7:0] o, input logic id, input logic par,
                           input logic [7:0] c0, input logic [7:0] c1);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_o",     32'(out_o),     32'(o));
        chk("out_id",    32'(out_id),    32'(id));
        chk("out_par",   32'(out_par),   32'(par));
        chk("done_cnt0", 32'(done_cnt0), 32'(c0));
        chk("done_cnt1", 32'(done_cnt1), 32'(c1));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst, v0;
        logic [7:0] a0, b0;
        logic       v1;
        logic [7:0] a1, b1;
        logic       ordy;
        logic       e_r0, e_r1, e_v;
        logic [7:0] e_o;
        logic       e_id, e_par;
        logic [7:0] e_c0, e_c1;
    } vec_t;

    function automatic vec_t mk(logic r, logic v0, logic [7:0] a0, logic [7:0] b0,
                                logic v1, logic [7:0] a1, logic [7:0] b1, logic ordy,
                                logic e_r0, logic e_r1, logic e_v, logic [7:0] e_o,
                                logic e_id, logic e_par, logic [7:0] e_c0, logic [7:0] e_c1);
        vec_t t;
        t.rst = r; t.v0 = v0; t.a0 = a0; t.b0 = b0; t.v1 = v1; t.a1 = a1; t.b1 = b1;
        t.ordy = ordy; t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_v = e_v; t.e_o = e_o;
        t.e_id = e_id; t.e_par = e_par; t.e_c0 = e_c0; t.e_c1 = e_c1;
        return t;
    endfunction

    vec_t tbl[13];

    // ---------------- reference model ----------------
    logic       m_valid, m_id, m_par, m_last;
    logic [7:0] m_o;
    logic [7:0] m_cnt[2];

    task automatic model_reset();
        m_valid = 0; m_o = 0; m_id = 0; m_par = 0; m_last = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic model_cycle(output logic g0, output logic g1);
        logic [7:0] x;
        g0 = 0; g1 = 0;
        if (!rst && (!m_valid || out_ready)) begin
            if (req0_valid && req1_valid) begin
                if (m_last == 1'b1) g0 = 1; else g1 = 1;
            end else if (req0_valid) g0 = 1;
            else if (req1_valid) g1 = 1;
        end
        #1;
        chk("rnd req0_ready", 32'(req0_ready), 32'(g0));
        chk("rnd req1_ready", 32'(req1_ready), 32'(g1));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && out_ready) m_cnt[m_id] = m_cnt[m_id] + 8'd1;
            if (g0 || g1) begin
                x = g1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
                m_o = x; m_id = g1; m_par = ($countones(x) % 2) == 1;
                m_valid = 1; m_last = g1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk_out(m_valid, m_o, m_id, m_par, m_cnt[0], m_cnt[1]);
    endtask

    initial begin
        logic       g0, g1;
        logic       pend[2];
        logic [1:0] p;

        s_v0 = 0; s_v1 = 0; s_a0 = 0; s_b0 = 0; s_a1 = 0; s_b1 = 0;
        rst = 1; out_ready = 0;
        req0_valid = 1; req0_a = 8'h55; req0_b = 8'h0A;
        req1_valid = 1; req1_a = 8'h33; req1_b = 8'h11;

        tbl[0]  = mk(0, 1, 8'h0F, 8'hFF, 0, 8'h00, 8'h00, 1,  1, 0, 1, 8'hF0, 0, 0, 8'd0, 8'd0);
        tbl[1]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'hF0, 0, 0, 8'd1, 8'd0);
        tbl[2]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 1,  0, 1, 1, 8'h03, 1, 0, 8'd1, 8'd0);
        tbl[3]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 1,  1, 0, 1, 8'h01, 0, 1, 8'd1, 8'd1);
        tbl[4]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 1,  0, 1, 1, 8'h03, 1, 0, 8'd2, 8'd1);
        tbl[5]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 0,  0, 0, 1, 8'h03, 1, 0, 8'd2, 8'd1);
        tbl[6]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 0,  0, 0, 1, 8'h03, 1, 0, 8'd2, 8'd1);
        tbl[7]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 0,  0, 0, 1, 8'h03, 1, 0, 8'd2, 8'd1);
        tbl[8]  = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 1,  1, 0, 1, 8'h01, 0, 1, 8'd2, 8'd2);
        tbl[9]  = mk(1, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 0,  0, 0, 0, 8'h00, 0, 0, 8'd0, 8'd0);
        tbl[10] = mk(0, 1, 8'h01, 8'h00, 1, 8'h02, 8'h01, 1,  1, 0, 1, 8'h01, 0, 1, 8'd0, 8'd0);
        tbl[11] = mk(0, 0, 8'h00, 8'h00, 1, 8'h02, 8'h01, 0,  0, 0, 1, 8'h01, 0, 1, 8'd0, 8'd0);
        tbl[12] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1,  0, 0, 0, 8'h01, 0, 1, 8'd1, 8'd0);

        // Reset with both channels requesting: readies must stay low.
        @(posedge clk);
        #1;
        chk("rst req0_ready", 32'(req0_ready), 32'd0);
        chk("rst req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_out(0, 8'h00, 0, 0, 8'd0, 8'd0);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; out_ready = tbl[i].ordy;
            req0_valid = tbl[i].v0; req0_a = tbl[i].a0; req0_b = tbl[i].b0;
            req1_valid = tbl[i].v1; req1_a = tbl[i].a1; req1_b = tbl[i].b1;
            #1;
            chk($sformatf("tbl%0d req0_ready", i), 32'(req0_ready), 32'(tbl[i].e_r0));
            chk($sformatf("tbl%0d req1_ready", i), 32'(req1_ready), 32'(tbl[i].e_r1));
            @(posedge clk);
            #1;
            chk_out(tbl[i].e_v, tbl[i].e_o, tbl[i].e_id, tbl[i].e_par, tbl[i].e_c0, tbl[i].e_c1);
        end

        // 256 ch1 results: counter reads 0xFF before the last drain, 0x00 after.
        rst = 1; req0_valid = 0; req1_valid = 0; out_ready = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            req1_valid = 1; req1_a = 8'(i); req1_b = 8'hA5;
            #1;
            chk("wrap req1_ready", 32'(req1_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("wrap out_o", 32'(out_o), 32'(8'hFF ^ 8'hA5));
        chk("wrap cnt1 pre", 32'(done_cnt1), 32'hFF);
        req1_valid = 0;
        @(posedge clk);
        #1;
        chk("wrap cnt1", 32'(done_cnt1), 32'h00);
        chk("wrap cnt0", 32'(done_cnt0), 32'h00);
        chk("wrap out_valid", 32'(out_valid), 32'd0);

        // Exhaustive 1-bit operand sweep: (a,b) = 00,10,01,11.
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            s_v0 = 1; s_a0 = p[0]; s_b0 = p[1];
            #1;
            chk("w1 req0_ready", 32'(s_r0), 32'd1);
            @(posedge clk);
            #1;
            chk("w1 out_o",   32'(s_o),   32'(p[0] ^ p[1]));
            chk("w1 out_par", 32'(s_par), 32'(p[0] ^ p[1]));
        end
        s_v0 = 0;

        // Randomized traffic with requesters honouring the stability rule.
        rst = 1; req0_valid = 0; req1_valid = 0;
        pend[0] = 0; pend[1] = 0;
        model_reset();
        model_cycle(g0, g1);
        rst = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend[0] && ($urandom % 3 != 0)) begin
                pend[0] = 1; req0_a = 8'($urandom); req0_b = 8'($urandom);
            end
            if (!pend[1] && ($urandom % 3 != 0)) begin
                pend[1] = 1; req1_a = 8'($urandom); req1_b = 8'($urandom);
            end
            req0_valid = pend[0];
            req1_valid = pend[1];
            out_ready  = ($urandom % 4) != 0;
            rst        = ($urandom % 100) == 0;
            model_cycle(g0, g1);
            if (g0) pend[0] = 0;
            if (g1) pend[1] = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
